pe_tbi_rx_sync: RTL and testbench



---
 rtl/pe_tbi_rx_sync.sv | 159 +++++++++++++++
 tb/tb_pe_tbi_rx_sync.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tbi_rx_sync.sv
// pe_tbi_rx_sync: TBI receive comma aligner and 1000BASE-X sync FSM.
// Locks onto comma boundaries, tracks even/odd parity, drives sync_status.
module pe_tbi_rx_sync #(
  parameter bit ALIGN_EN = 1'b1
) (
  input  logic       tbi_rx_clk,
  input  logic       tbi_rx_rst,
  input  logic [9:0] rx_tbi,
  input  logic       code_err,
  output logic [9:0] rx_code_o,
  output logic       rx_comma,
  output logic       rx_even,
  output logic       sync_status,
  output logic [3:0] align_ofs,
  output logic       realign
);

  localparam logic [2:0] ST_LOS  = 3'd0;
  localparam logic [2:0] ST_CD1  = 3'd1;
  localparam logic [2:0] ST_CD2  = 3'd2;
  localparam logic [2:0] ST_CD3  = 3'd3;
  localparam logic [2:0] ST_AS1  = 3'd4;
  localparam logic [2:0] ST_AS2  = 3'd5;
  localparam logic [2:0] ST_SYNC = 3'd6;

  logic [9:0]  prev_q;
  logic [9:0]  code_q;
  logic        comma_q;
  logic        even_q;
  logic [3:0]  ofs_q;
  logic        realign_q;
  logic [2:0]  state_q, state_d;
  logic [1:0]  bad_q, bad_d;
  logic [1:0]  good_q, good_d;

  logic [19:0] hist;
  logic        hit;
  logic [3:0]  hit_ofs;
  logic        use_new;
  logic [3:0]  ofs_d;
  logic [9:0]  word_d;
  logic        cgbad;

  // bits a..g (code[0]..code[6]) = 0011111 or 1100000
  function automatic logic is_comma(input logic [9:0] c);
    return (c[6:0] == 7'b1111100) || (c[6:0] == 7'b0000011);
  endfunction

  // Offset k: word starts k bits before the current word boundary,
  // so k=0 is rx_tbi itself and k>0 borrows the tail of prev.
  function automatic logic [9:0] pick(input logic [19:0] h,
                                      input logic [3:0]  k);
    logic [19:0] s;
    s = h >> (5'd10 - {1'b0, k});
    return s[9:0];
  endfunction

  assign hist = {rx_tbi, prev_q};

  // Lowest comma offset in the window (scan high to low, last hit wins)
  always_comb begin
    hit     = 1'b0;
    hit_ofs = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (is_comma(pick(hist, 4'(k)))) begin
        hit     = 1'b1;
        hit_ofs = 4'(k);
      end
    end
  end

  assign use_new = ALIGN_EN && (state_q == ST_LOS) && hit;
  assign ofs_d   = use_new ? hit_ofs : ofs_q;
  assign word_d  = pick(hist, ofs_d);

  assign rx_even     = even_q | ((state_q == ST_LOS) & comma_q);
  assign sync_status = (state_q == ST_SYNC);
  assign cgbad       = code_err | (comma_q & ~rx_even);

  assign rx_code_o = code_q;
  assign rx_comma  = comma_q;
  assign align_ofs = ofs_q;
  assign realign   = realign_q;

  // Alignment datapath: capture history, aligned word, offset, parity
  always_ff @(posedge tbi_rx_clk or posedge tbi_rx_rst) begin
    if (tbi_rx_rst) begin
      prev_q    <= '0;
      code_q    <= '0;
      comma_q   <= 1'b0;
      even_q    <= 1'b0;
      ofs_q     <= '0;
      realign_q <= 1'b0;
    end else begin
      prev_q    <= rx_tbi;
      code_q    <= word_d;
      comma_q   <= is_comma(word_d);
      even_q    <= ~rx_even;
      ofs_q     <= ofs_d;
      realign_q <= use_new && (hit_ofs != ofs_q);
    end
  end

  // Next state and good/bad counters; cgbad beats comma progress
  always_comb begin
    state_d = state_q;
    bad_d   = '0;
    good_d  = '0;
    unique case (state_q)
      ST_LOS: if (comma_q) state_d = ST_CD1;
      ST_CD1: state_d = (!cgbad && !comma_q) ? ST_AS1 : ST_LOS;
      ST_CD2: state_d = (!cgbad && !comma_q) ? ST_AS2 : ST_LOS;
      ST_CD3: state_d = (!cgbad && !comma_q) ? ST_SYNC : ST_LOS;
      ST_AS1: begin
        if (cgbad) state_d = ST_LOS;
        else if (comma_q && rx_even) state_d = ST_CD2;
      end
      ST_AS2: begin
        if (cgbad) state_d = ST_LOS;
        else if (comma_q && rx_even) state_d = ST_CD3;
      end
      ST_SYNC: begin
        bad_d  = bad_q;
        good_d = good_q;
        if (cgbad) begin
          good_d = '0;
          if (bad_q == 2'd3) begin
            state_d = ST_LOS;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + 2'd1;
          end
        end else if (bad_q != 2'd0) begin
          if (good_q == 2'd3) begin
            bad_d  = bad_q - 2'd1;
            good_d = '0;
          end else begin
            good_d = good_q + 2'd1;
          end
        end
      end
      default: state_d = ST_LOS;
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge tbi_rx_clk or posedge tbi_rx_rst) begin
    if (tbi_rx_rst) begin
      state_q <= ST_LOS;
      bad_q   <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
    end
  end

endmodule

// File: tb/tb_pe_tbi_rx_sync.sv
// tb_pe_tbi_rx_sync: directed bench for pe_tbi_rx_sync.
// Idle K28.5/D16.2 streams, bit slips, error bursts and mid-run reset.
module tb_pe_tbi_rx_sync;

  localparam logic [9:0] K = 10'h17C;
  localparam logic [9:0] D = 10'h2B6;

  typedef struct packed {
    logic [9:0] code;
    logic       comma;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_tbi;
  logic       code_err;
  logic [9:0] rx_code_o;
  logic       rx_comma, rx_even, sync_status, realign;
  logic [3:0] align_ofs;

  logic [9:0] c0_code;
  logic       c0_comma, c0_even, c0_sync, c0_realign;
  logic [3:0] c0_ofs;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   idx;
  logic dec_en = 1'b0;

  always #5 clk = ~clk;

  pe_tbi_rx_sync #(.ALIGN_EN(1'b1)) dut (
    .tbi_rx_clk (clk),
    .tbi_rx_rst (rst),
    .rx_tbi     (rx_tbi),
    .code_err   (code_err),
    .rx_code_o  (rx_code_o),
    .rx_comma   (rx_comma),
    .rx_even    (rx_even),
    .sync_status(sync_status),
    .align_ofs  (align_ofs),
    .realign    (realign)
  );

  pe_tbi_rx_sync #(.ALIGN_EN(1'b0)) u_dut0 (
    .tbi_rx_clk (clk),
    .tbi_rx_rst (rst),
    .rx_tbi     (rx_tbi),
    .code_err   (code_err),
    .rx_code_o  (c0_code),
    .rx_comma   (c0_comma),
    .rx_even    (c0_even),
    .sync_status(c0_sync),
    .align_ofs  (c0_ofs),
    .realign    (c0_realign)
  );

  function automatic logic [9:0] sw(input int i);
    return (i % 2 == 0) ? K : D;
  endfunction

  // Idle stream word i with the first d bits dropped from the wire
  function automatic logic [9:0] gen(input int i, input int d);
    logic [19:0] p;
    p = {sw(i + 1), sw(i)} >> d;
    return p[9:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] w, input logic err,
                      input logic pv, input logic [9:0] ec);
    exp_t e;
    @(negedge clk);
    code_err = err | (dec_en & (rx_code_o !== K) & (rx_code_o !== D));
    rx_tbi = w;
    if (pv) begin
      e.code  = ec;
      e.comma = (ec == K);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("code", 32'(rx_code_o), 32'(e.code));
      chk("comma", 32'(rx_comma), 32'(e.comma));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_tbi = '0;
    code_err = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    logic [9:0] ec;
    int ph;
    rst = 1'b1;
    rx_tbi = '0;
    code_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_code", 32'(rx_code_o), 32'(0));
    chk("rst_comma", 32'(rx_comma), 32'(0));
    chk("rst_even", 32'(rx_even), 32'(0));
    chk("rst_sync", 32'(sync_status), 32'(0));
    chk("rst_ofs", 32'(align_ofs), 32'(0));
    chk("rst_realign", 32'(realign), 32'(0));
    rst = 1'b0;

    // aligned idle stream
    for (int s = 1; s <= 30; s++) begin
      w = gen(s - 1, 0);
      step(w, 1'b0, 1'b1, w);
      chk("t1_sync", 32'(sync_status), 32'(s >= 7));
      chk("t1_ofs", 32'(align_ofs), 32'(0));
      chk("t1_realign", 32'(realign), 32'(0));
      if (w == K) chk("t1_even", 32'(rx_even), 32'(1));
    end

    // stream slipped by 3 bits
    do_reset();
    for (int s = 1; s <= 20; s++) begin
      w  = gen(s - 1, 3);
      ec = (s <= 2) ? w : gen(s - 1, 0);
      step(w, 1'b0, 1'b1, ec);
      chk("t2_sync", 32'(sync_status), 32'(s >= 9));
      chk("t2_realign", 32'(realign), 32'(s == 3));
      chk("t2_ofs", 32'(align_ofs), 32'((s >= 3) ? 3 : 0));
      chk("t2_noalign_sync", 32'(c0_sync), 32'(0));
      if (s >= 3 && ec == K) chk("t2_even", 32'(rx_even), 32'(1));
    end

    // odd comma while in ACQUIRE_SYNC_1
    do_reset();
    for (int s = 1; s <= 14; s++) begin
      w = (s == 1 || (s >= 4 && s % 2 == 0)) ? K : D;
      step(w, 1'b0, 1'b1, w);
      chk("t3_sync", 32'(sync_status), 32'(s >= 12));
      if (s == 4) chk("t3_odd", 32'(rx_even), 32'(0));
      if (s == 6) chk("t3_even", 32'(rx_even), 32'(1));
    end

    // four consecutive errors in sync
    do_reset();
    for (int s = 1; s <= 14; s++) begin
      w = gen(s - 1, 0);
      step(w, 1'(s >= 11), 1'b1, w);
      chk("t4_sync", 32'(sync_status), 32'(s >= 7 && s < 14));
    end

    // three errors separated by four good words
    do_reset();
    idx = 0;
    for (int s = 1; s <= 25; s++) begin
      w = gen(idx, 0);
      idx++;
      step(w, 1'(s == 11 || s == 16 || s == 21), 1'b1, w);
      chk("t4b_sync", 32'(sync_status), 32'(s >= 7));
      if (s == 11 || s == 15 || s == 16 || s == 20 || s == 21 || s == 25)
        chk("t4b_bad", 32'(dut.bad_q),
            32'((s == 11 || s == 16 || s == 21) ? 1 : 0));
    end

    // 5-bit slip while in sync: hold, lose, realign, resync
    dec_en = 1'b1;
    ph = 0;
    for (int j = 0; j < 40 && ph < 3; j++) begin
      step(gen(idx, 5), 1'b0, 1'b0, 10'h0);
      idx++;
      if (ph == 0) begin
        if (!sync_status) ph = 1;
        else begin
          chk("t5_ofs_hold", 32'(align_ofs), 32'(0));
          chk("t5_realign_hold", 32'(realign), 32'(0));
        end
      end else if (ph == 1) begin
        if (realign) begin
          chk("t5_ofs_new", 32'(align_ofs), 32'(5));
          ph = 2;
        end else begin
          chk("t5_sync_low", 32'(sync_status), 32'(0));
        end
      end else if (sync_status) begin
        chk("t5_ofs_lock", 32'(align_ofs), 32'(5));
        ph = 3;
      end
    end
    chk("t5_relock", 32'(ph), 32'(3));
    dec_en = 1'b0;

    // reset asserted in COMMA_DETECT_2
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      w = gen(s - 1, 0);
      step(w, 1'b0, 1'b1, w);
    end
    chk("t6_state_cd2", 32'(dut.state_q), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_code", 32'(rx_code_o), 32'(0));
    chk("t6_comma", 32'(rx_comma), 32'(0));
    chk("t6_even", 32'(rx_even), 32'(0));
    chk("t6_sync", 32'(sync_status), 32'(0));
    chk("t6_ofs", 32'(align_ofs), 32'(0));
    chk("t6_realign", 32'(realign), 32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      w = gen(s - 1, 0);
      step(w, 1'b0, 1'b1, w);
      chk("t6_resync", 32'(sync_status), 32'(s >= 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
